// File: rtl/icache_direct_if.sv
// Fetch-side, memory-side, snoop and statistics signals of the direct-mapped
// instruction cache. The environment (CPU/memory) drives through master, the cache uses slave.
interface icache_direct_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_req;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_data;
  logic                 cpu_ready;
  logic                 mem_read;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 snoop_we;
  logic [WORD_SIZE-1:0] snoop_addr;
  logic                 flush;
  logic [WORD_SIZE-1:0] hit_count;
  logic [WORD_SIZE-1:0] miss_count;

  modport master (
    output cpu_req, cpu_addr, mem_data, snoop_we, snoop_addr, flush,
    input  cpu_data, cpu_ready, mem_read, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  cpu_req, cpu_addr, mem_data, snoop_we, snoop_addr, flush,
    output cpu_data, cpu_ready, mem_read, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are answered combinationally
// in IDLE; a miss streams a full line from the 1-cycle-latency instruction
// port (FILL issues, DRAIN catches the last word). Data-port writes are snooped
// to drop stale lines; flush drops everything and aborts an in-flight fill.
module icache_direct #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input logic           clk,
  input logic           reset_n,
  icache_direct_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0]     LAST    = OFF_W'(LINE_WORDS - 1);
  localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_LINES-1:0]                                r_valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]                     r_tag;
  logic [NUM_LINES-1:0][LINE_WORDS-1:0][WORD_SIZE-1:0] r_data;

  logic [TAG_W-1:0]     r_fill_tag;
  logic [IDX_W-1:0]     r_fill_idx;
  logic [OFF_W-1:0]     r_issue_cnt;
  logic                 r_fill_kill;
  logic                 r_mem_read;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_hit_cnt;
  logic [WORD_SIZE-1:0] r_miss_cnt;

  logic [TAG_W-1:0]     w_tag, w_snp_tag;
  logic [IDX_W-1:0]     w_idx, w_snp_idx;
  logic [OFF_W-1:0]     w_off;
  logic                 w_hit, w_ready, w_miss_start, w_snp_fill, w_snp_match;
  logic                 w_mem_read_nxt;
  logic [WORD_SIZE-1:0] w_mem_addr_nxt;

  assign w_tag     = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign w_idx     = bus.cpu_addr[OFF_W +: IDX_W];
  assign w_off     = bus.cpu_addr[OFF_W-1:0];
  assign w_snp_tag = bus.snoop_addr[WORD_SIZE-1 -: TAG_W];
  assign w_snp_idx = bus.snoop_addr[OFF_W +: IDX_W];

  // Lookups only count in IDLE; flush suppresses both hits and new misses.
  assign w_hit        = (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ready      = bus.cpu_req && w_hit && !bus.flush;
  assign w_miss_start = (r_state == IDLE) && bus.cpu_req && !w_hit && !bus.flush;

  // A snoop into the line being filled must keep it from being validated.
  assign w_snp_fill  = bus.snoop_we && (r_state != IDLE) &&
                       (w_snp_tag == r_fill_tag) && (w_snp_idx == r_fill_idx);
  assign w_snp_match = bus.snoop_we && (r_tag[w_snp_idx] == w_snp_tag);

  assign bus.cpu_ready  = w_ready;
  assign bus.cpu_data   = w_ready ? r_data[w_idx][w_off] : '0;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and the next memory request (address/read are registered).
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_read_nxt = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    unique case (r_state)
      IDLE: begin
        if (w_miss_start) begin
          w_state_nxt    = FILL;
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = {w_tag, w_idx, {OFF_W{1'b0}}};
        end
      end
      FILL: begin
        if (bus.flush)                w_state_nxt = IDLE;
        else if (r_issue_cnt == LAST) w_state_nxt = DRAIN;
        else begin
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = {r_fill_tag, r_fill_idx, r_issue_cnt + OFF_W'(1)};
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state: memory port, fill bookkeeping, valid bits, counters.
  // Later statements win: DRAIN validate < snoop clear < flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_issue_cnt <= '0;
      r_fill_kill <= 1'b0;
    end else begin
      r_mem_read <= w_mem_read_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      if (w_ready && r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss_start) begin
        r_fill_tag     <= w_tag;
        r_fill_idx     <= w_idx;
        r_issue_cnt    <= '0;
        r_fill_kill    <= 1'b0;
        r_valid[w_idx] <= 1'b0;  // line contents are overwritten during the fill
        if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + 1'b1;
      end else if (r_state == FILL) begin
        r_issue_cnt <= r_issue_cnt + OFF_W'(1);
      end
      if (w_snp_fill) r_fill_kill <= 1'b1;
      if (r_state == DRAIN && !(r_fill_kill || w_snp_fill)) r_valid[r_fill_idx] <= 1'b1;
      // During DRAIN the old tag at fill_idx is stale; fill-line snoops go via kill.
      if (w_snp_match && !(r_state == DRAIN && w_snp_idx == r_fill_idx))
        r_valid[w_snp_idx] <= 1'b0;
      if (bus.flush) begin
        r_valid     <= '0;
        r_fill_kill <= 1'b0;
      end
    end
  end

  // Line arrays: word k arrives the cycle after its issue; DRAIN takes the last.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == FILL && r_issue_cnt != '0)
        r_data[r_fill_idx][r_issue_cnt - OFF_W'(1)] <= bus.mem_data;
      if (r_state == DRAIN) begin
        r_data[r_fill_idx][LAST] <= bus.mem_data;
        r_tag[r_fill_idx]        <= r_fill_tag;
      end
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: reset, miss/fill timing, back-to-back hits,
// conflict eviction, snoop invalidation, flush and mid-fill reset.
module tb_icache_direct;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  icache_direct_if bus ();
  icache_direct dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Instruction port model: registered read, data valid the cycle after mem_read.
  always @(posedge clk) if (bus.mem_read) bus.mem_data <= mem[bus.mem_addr[7:0]];

  // Drive a fetch until cpu_ready (bounded); lat = cycles from first request.
  task automatic do_fetch(input logic [15:0] a, output int lat, output logic [15:0] d);
    lat = -1; d = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = a; #1;
      if (bus.cpu_ready === 1'b1) begin lat = c; d = bus.cpu_data; break; end
    end
    @(negedge clk); bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %h want 0", bus.mem_read); end
    n_cmp++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    n_cmp++; if (bus.hit_count !== 16'h0) begin n_fail++; $display("FAIL reset_hit_count: got %h want 0000", bus.hit_count); end
    n_cmp++; if (bus.miss_count !== 16'h0) begin n_fail++; $display("FAIL reset_miss_count: got %h want 0000", bus.miss_count); end
    n_cmp++; if (bus.cpu_ready !== 1'b0 || bus.cpu_data !== 16'h0) begin n_fail++; $display("FAIL reset_cpu: got ready=%h data=%h want 0/0000", bus.cpu_ready, bus.cpu_data); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_miss_fill;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0024; #1;
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'(35 + c)) begin n_fail++;
          $display("FAIL fill_issue[%0d]: got read=%h addr=%h want 1/%h", c, bus.mem_read, bus.mem_addr, 16'(35 + c)); end
      end else if (c == 0 || c == 5) begin
        n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL fill_idle_read[%0d]: got %h want 0", c, bus.mem_read); end
      end
      if (c < 6) begin
        n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_low[%0d]: got %h want 0", c, bus.cpu_ready); end
      end else begin
        n_cmp++; if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== 16'hF01C) begin n_fail++;
          $display("FAIL fill_hit_T6: got ready=%h data=%h want 1/f01c", bus.cpu_ready, bus.cpu_data); end
      end
    end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd1) begin n_fail++;
      $display("FAIL fill_counts: got miss=%0d hit=%0d want 1/1", bus.miss_count, bus.hit_count); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a [3];
    logic [15:0] e [3];
    a = '{16'h0025, 16'h0026, 16'h0027};
    e = '{16'h6100, 16'hF41C, 16'h6200};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = a[i]; #1;
      n_cmp++; if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== e[i] || bus.mem_read !== 1'b0) begin n_fail++;
        $display("FAIL b2b_hit[%0d]: got ready=%h data=%h read=%h want 1/%h/0", i, bus.cpu_ready, bus.cpu_data, bus.mem_read, e[i]); end
    end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.hit_count !== 16'd4) begin n_fail++; $display("FAIL b2b_hit_count: got %0d want 4", bus.hit_count); end
  endtask

  task automatic test_conflict;
    int lat; logic [15:0] d;
    do_fetch(16'h0044, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'hF1C1) begin n_fail++; $display("FAIL conflict_0044: got lat=%0d data=%h want 6/f1c1", lat, d); end
    do_fetch(16'h0024, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'hF01C) begin n_fail++; $display("FAIL conflict_0024: got lat=%0d data=%h want 6/f01c", lat, d); end
    n_cmp++; if (bus.miss_count !== 16'd3) begin n_fail++; $display("FAIL conflict_miss_count: got %0d want 3", bus.miss_count); end
  endtask

  task automatic test_snoop;
    int lat; logic [15:0] d;
    // Same index, different tag: line 0x24 must survive.
    @(negedge clk); bus.snoop_we = 1'b1; bus.snoop_addr = 16'h0046;
    @(negedge clk); bus.snoop_we = 1'b0;
    do_fetch(16'h0024, lat, d);
    n_cmp++; if (lat !== 0 || d !== 16'hF01C) begin n_fail++; $display("FAIL snoop_other_tag: got lat=%0d data=%h want 0/f01c", lat, d); end
    // Matching snoop invalidates the line.
    @(negedge clk); bus.snoop_we = 1'b1; bus.snoop_addr = 16'h0026;
    @(negedge clk); bus.snoop_we = 1'b0;
    do_fetch(16'h0024, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'hF01C) begin n_fail++; $display("FAIL snoop_inval: got lat=%0d data=%h want 6/f01c", lat, d); end
    // Snoop coinciding with a hit: old data now, invalid next cycle.
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0024; bus.snoop_we = 1'b1; bus.snoop_addr = 16'h0025; #1;
    n_cmp++; if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== 16'hF01C) begin n_fail++;
      $display("FAIL snoop_same_cycle_hit: got ready=%h data=%h want 1/f01c", bus.cpu_ready, bus.cpu_data); end
    @(negedge clk); bus.snoop_we = 1'b0; #1;
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL snoop_next_cycle_miss: got %h want 0", bus.cpu_ready); end
    do_fetch(16'h0024, lat, d);
    n_cmp++; if (lat !== 5 || d !== 16'hF01C) begin n_fail++; $display("FAIL snoop_refill: got lat=%0d data=%h want 5/f01c", lat, d); end
    // Snoop into the line being filled: not validated at DRAIN.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
      bus.snoop_we = (c == 2); bus.snoop_addr = 16'h0021; #1;
      if (c == 6) begin
        n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL snoop_fill_kill: got ready=%h want 0", bus.cpu_ready); end
      end
    end
    do_fetch(16'h0020, lat, d);
    n_cmp++; if (lat !== 5 || d !== 16'h1234) begin n_fail++; $display("FAIL snoop_fill_refetch: got lat=%0d data=%h want 5/1234", lat, d); end
    n_cmp++; if (bus.miss_count !== 16'd7 || bus.hit_count !== 16'd11) begin n_fail++;
      $display("FAIL snoop_counts: got miss=%0d hit=%0d want 7/11", bus.miss_count, bus.hit_count); end
  endtask

  task automatic test_flush;
    int lat; logic [15:0] d;
    // Flush beats a hit.
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0024; bus.flush = 1'b1; #1;
    n_cmp++; if (bus.cpu_ready !== 1'b0 || bus.cpu_data !== 16'h0) begin n_fail++;
      $display("FAIL flush_hit: got ready=%h data=%h want 0/0000", bus.cpu_ready, bus.cpu_data); end
    @(negedge clk); bus.flush = 1'b0; bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.hit_count !== 16'd11) begin n_fail++; $display("FAIL flush_hit_count: got %0d want 11", bus.hit_count); end
    // Flush beats a miss.
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0044; bus.flush = 1'b1; #1;
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_miss_ready: got %h want 0", bus.cpu_ready); end
    @(negedge clk); bus.flush = 1'b0; bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.miss_count !== 16'd7) begin n_fail++;
      $display("FAIL flush_miss: got read=%h miss=%0d want 0/7", bus.mem_read, bus.miss_count); end
    do_fetch(16'h0020, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'h1234) begin n_fail++; $display("FAIL flush_cleared_0020: got lat=%0d data=%h want 6/1234", lat, d); end
    // Flush in the issue_cnt=2 cycle of a fill of 0x44.
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0044; bus.flush = (c == 3); #1;
    end
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0046) begin n_fail++;
      $display("FAIL flush_fill_issue2: got read=%h addr=%h want 1/0046", bus.mem_read, bus.mem_addr); end
    @(negedge clk); bus.flush = 1'b0; bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL flush_fill_abort: got read=%h want 0", bus.mem_read); end
    do_fetch(16'h0044, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'hF1C1) begin n_fail++; $display("FAIL flush_refetch: got lat=%0d data=%h want 6/f1c1", lat, d); end
    do_fetch(16'h0020, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'h1234) begin n_fail++; $display("FAIL flush_all_invalid: got lat=%0d data=%h want 6/1234", lat, d); end
    n_cmp++; if (bus.miss_count !== 16'd11) begin n_fail++; $display("FAIL flush_miss_count: got %0d want 11", bus.miss_count); end
  endtask

  task automatic test_reset_mid_fill;
    int lat; logic [15:0] d;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0060; reset_n = (c != 2);
    end
    @(negedge clk); reset_n = 1'b1; bus.cpu_req = 1'b0; #1;
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin n_fail++;
      $display("FAIL midfill_reset: got read=%h hit=%0d miss=%0d want 0/0/0", bus.mem_read, bus.hit_count, bus.miss_count); end
    do_fetch(16'h0020, lat, d);
    n_cmp++; if (lat !== 6 || d !== 16'h1234) begin n_fail++; $display("FAIL midfill_remiss: got lat=%0d data=%h want 6/1234", lat, d); end
    n_cmp++; if (bus.miss_count !== 16'd1) begin n_fail++; $display("FAIL midfill_miss_count: got %0d want 1", bus.miss_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h20] = 16'h1234;
    mem[8'h24] = 16'hF01C; mem[8'h25] = 16'h6100; mem[8'h26] = 16'hF41C; mem[8'h27] = 16'h6200;
    mem[8'h44] = 16'hF1C1;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.snoop_we = 1'b0; bus.snoop_addr = '0; bus.flush = 1'b0;
    bus.mem_data = '0;
    test_reset;
    test_miss_fill;
    test_back_to_back;
    test_conflict;
    test_snoop;
    test_flush;
    test_reset_mid_fill;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
